// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store data memory for the M stage of the RV32 core.
// Byte/halfword/word accesses with sign/zero extension, a fixed access
// latency with a stall handshake to the hazard unit, and registered
// error reporting (illegal funct3, misaligned, out of range).
//
// state | meaning
// IDLE  | waiting for req_valid; request is captured on the accepting edge
// WAIT  | counting down the access latency; latched request is held
// RESP  | done pulse; rdata/err/err_code valid; inputs ignored
module lsu_dmem #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  count;
  logic        latWe;
  logic [2:0]  latF3;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        curWe;
  logic [2:0]  curF3;
  logic [31:0] curAddr;
  logic [31:0] curWdata;
  logic        enterResp;
  logic [AW-1:0] wordIdx;
  logic [1:0]  lane;
  logic        illegal;
  logic        misaligned;
  logic        outOfRange;
  logic [1:0]  code;
  logic [31:0] memWord;
  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic [31:0] loadData;
  logic [31:0] storeData;
  logic [3:0]  byteEn;

  // Access decode; with zero latency the access happens on the accepting
  // edge, so the live inputs are used instead of the latched copy.
  always_comb begin
    curWe    = (state == IDLE) ? req_we : latWe;
    curF3    = (state == IDLE) ? funct3 : latF3;
    curAddr  = (state == IDLE) ? addr   : latAddr;
    curWdata = (state == IDLE) ? wdata  : latWdata;

    enterResp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                ((state == WAIT) && (count == 3'd1));

    wordIdx = curAddr[AW+1:2];
    lane    = curAddr[1:0];

    if (curWe)
      illegal = !(curF3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(curF3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((curF3[1:0] == 2'b01) && curAddr[0]) ||
                 ((curF3[1:0] == 2'b10) && (curAddr[1:0] != 2'b00));
    outOfRange = {2'b00, curAddr[31:2]} >= 32'(DEPTH_WORDS);

    if (illegal)         code = 2'b11;
    else if (misaligned) code = 2'b01;
    else if (outOfRange) code = 2'b10;
    else                 code = 2'b00;

    memWord = mem[wordIdx];
    selByte = memWord[{lane, 3'b000} +: 8];
    selHalf = lane[1] ? memWord[31:16] : memWord[15:0];

    case (curF3)
      3'b000:  loadData = {{24{selByte[7]}}, selByte};
      3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
      3'b010:  loadData = memWord;
      3'b100:  loadData = {24'd0, selByte};
      3'b101:  loadData = {16'd0, selHalf};
      default: loadData = 32'd0;
    endcase

    case (curF3[1:0])
      2'b00: begin
        storeData = {4{curWdata[7:0]}};
        byteEn    = 4'b0001 << lane;
      end
      2'b01: begin
        storeData = {2{curWdata[15:0]}};
        byteEn    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = curWdata;
        byteEn    = 4'b1111;
      end
    endcase
  end

  // Stall the pipeline from acceptance until the response cycle.
  always_comb begin
    stall = !reset && (((state == IDLE) && req_valid) || (state == WAIT));
  end

  // Sequencer plus registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 3'd0;
      latWe    <= 1'b0;
      latF3    <= 3'd0;
      latAddr  <= 32'd0;
      latWdata <= 32'd0;
      rdata    <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            latWe    <= req_we;
            latF3    <= funct3;
            latAddr  <= addr;
            latWdata <= wdata;
            count    <= LAT;
            state    <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 3'd1;
          if (count == 3'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enterResp) begin
        done     <= 1'b1;
        err      <= (code != 2'b00);
        err_code <= code;
        rdata    <= ((code != 2'b00) || curWe) ? 32'd0 : loadData;
      end else begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'b00;
        rdata    <= 32'd0;
      end
    end
  end

  // Store commit on the edge entering RESP; faulted stores never write.
  always_ff @(posedge clk) begin
    if (!reset && enterResp && curWe && (code == 2'b00)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem: a LATENCY=2 instance driven from a vector table and
// a LATENCY=0 instance, with a queue scoreboard checking each done pulse.
module tb_lsu_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        reqValid [2];
  logic        reqWe    [2];
  logic [2:0]  f3       [2];
  logic [31:0] addrIn   [2];
  logic [31:0] wdataIn  [2];
  logic [31:0] rdata    [2];
  logic        done     [2];
  logic        stall    [2];
  logic        err      [2];
  logic [1:0]  errCode  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] r;
    logic        e;
    logic [1:0]  c;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        e;
    logic [1:0]  c;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t q0[$];
  exp_t q1[$];

  lsu_dmem #(.DEPTH_WORDS(64), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .req_valid(reqValid[0]), .req_we(reqWe[0]),
    .funct3(f3[0]), .addr(addrIn[0]), .wdata(wdataIn[0]), .rdata(rdata[0]),
    .done(done[0]), .stall(stall[0]), .err(err[0]), .err_code(errCode[0])
  );

  lsu_dmem #(.DEPTH_WORDS(64), .LATENCY(0)) u1 (
    .clk(clk), .reset(reset), .req_valid(reqValid[1]), .req_we(reqWe[1]),
    .funct3(f3[1]), .addr(addrIn[1]), .wdata(wdataIn[1]), .rdata(rdata[1]),
    .done(done[1]), .stall(stall[1]), .err(err[1]), .err_code(errCode[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic addv(input logic we, input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] r, input logic e,
                      input logic [1:0] c);
    vec_t v;
    v.we = we; v.f3 = fn; v.a = a; v.wd = wd; v.r = r; v.e = e; v.c = c;
    vecs.push_back(v);
  endtask

  task automatic pushExp(input int sel, input vec_t v, input int id);
    exp_t e;
    e.r = v.r; e.e = v.e; e.c = v.c; e.id = id;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int sel, input vec_t v);
    reqValid[sel] = 1'b1;
    reqWe[sel]    = v.we;
    f3[sel]       = v.f3;
    addrIn[sel]   = v.a;
    wdataIn[sel]  = v.wd;
  endtask

  // Drop req_valid and scramble the other inputs so latching is exercised.
  task automatic scramble(input int sel);
    reqValid[sel] = 1'b0;
    reqWe[sel]    = 1'($urandom);
    f3[sel]       = 3'($urandom);
    addrIn[sel]   = $urandom;
    wdataIn[sel]  = $urandom;
  endtask

  task automatic access(input int sel, input vec_t v, input int id);
    int lat;
    int cyc;
    int stalls;
    lat = (sel == 0) ? 2 : 0;
    cyc = 0;
    stalls = 0;
    pushExp(sel, v, id);
    @(negedge clk);
    drive(sel, v);
    #1;
    if (stall[sel]) stalls++;
    @(posedge clk);
    #1;
    scramble(sel);
    do begin
      @(negedge clk);
      cyc++;
      if (stall[sel]) stalls++;
    end while (!done[sel] && cyc < 20);
    chk($sformatf("done_latency_d%0d_v%0d", sel, id), cyc, lat + 1);
    chk($sformatf("stall_cycles_d%0d_v%0d", sel, id), stalls, lat + 1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done[0]) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_d0 actual=1 expected=0");
      end else begin
        e = q0.pop_front();
        chk($sformatf("rdata_d0_v%0d", e.id), rdata[0], e.r);
        chk($sformatf("err_d0_v%0d", e.id), 32'(err[0]), 32'(e.e));
        chk($sformatf("err_code_d0_v%0d", e.id), 32'(errCode[0]), 32'(e.c));
      end
    end
    if (done[1]) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_d1 actual=1 expected=0");
      end else begin
        e = q1.pop_front();
        chk($sformatf("rdata_d1_v%0d", e.id), rdata[1], e.r);
        chk($sformatf("err_d1_v%0d", e.id), 32'(err[1]), 32'(e.e));
        chk($sformatf("err_code_d1_v%0d", e.id), 32'(errCode[1]), 32'(e.c));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int cyc;

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0; reqWe[s] = 1'b0; f3[s] = 3'd0;
      addrIn[s] = 32'd0; wdataIn[s] = 32'd0;
    end
    reqValid[0] = 1'b1;
    #3;
    chk("stall_forced_low_in_reset", 32'(stall[0]), 32'd0);
    reqValid[0] = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_rdata_d%0d", s), rdata[s], 32'd0);
      chk($sformatf("reset_done_d%0d", s), 32'(done[s]), 32'd0);
      chk($sformatf("reset_err_d%0d", s), 32'(err[s]), 32'd0);
      chk($sformatf("reset_err_code_d%0d", s), 32'(errCode[s]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("idle_stall_d%0d", s), 32'(stall[s]), 32'd0);
      chk($sformatf("idle_done_d%0d", s), 32'(done[s]), 32'd0);
    end

    // we, funct3, addr, wdata -> rdata, err, err_code
    addv(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 0, 2'b00);
    addv(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2'b00);
    addv(1, 3'b000, 32'h13,  32'h000000A5, 32'h00000000, 0, 2'b00);
    addv(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFA5, 0, 2'b00);
    addv(0, 3'b100, 32'h13,  32'h0,        32'h000000A5, 0, 2'b00);
    addv(0, 3'b010, 32'h10,  32'h0,        32'hA5ADBEEF, 0, 2'b00);
    addv(1, 3'b001, 32'h12,  32'h00008001, 32'h00000000, 0, 2'b00);
    addv(0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 0, 2'b00);
    addv(0, 3'b101, 32'h12,  32'h0,        32'h00008001, 0, 2'b00);
    addv(0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0, 2'b00);
    addv(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 0, 2'b00);
    addv(0, 3'b100, 32'h12,  32'h0,        32'h00000001, 0, 2'b00);
    addv(0, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 0, 2'b00);
    addv(0, 3'b001, 32'h11,  32'h0,        32'h00000000, 1, 2'b01);
    addv(1, 3'b010, 32'h5,   32'h12345678, 32'h00000000, 1, 2'b01);
    addv(0, 3'b010, 32'h4,   32'h0,        32'h00000000, 0, 2'b00);
    addv(1, 3'b010, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1, 2'b10);
    addv(0, 3'b010, 32'h0,   32'h0,        32'h00000000, 0, 2'b00);
    addv(0, 3'b010, 32'h100, 32'h0,        32'h00000000, 1, 2'b10);
    addv(0, 3'b011, 32'h0,   32'h0,        32'h00000000, 1, 2'b11);
    addv(1, 3'b100, 32'h0,   32'hFFFFFFFF, 32'h00000000, 1, 2'b11);
    addv(0, 3'b010, 32'h0,   32'h0,        32'h00000000, 0, 2'b00);
    addv(0, 3'b011, 32'h101, 32'h0,        32'h00000000, 1, 2'b11);
    addv(0, 3'b010, 32'h101, 32'h0,        32'h00000000, 1, 2'b01);
    addv(0, 3'b100, 32'h100, 32'h0,        32'h00000000, 1, 2'b10);
    addv(1, 3'b010, 32'hFC,  32'h76543210, 32'h00000000, 0, 2'b00);
    addv(0, 3'b010, 32'hFC,  32'h0,        32'h76543210, 0, 2'b00);
    addv(1, 3'b001, 32'h1E,  32'hABCD1234, 32'h00000000, 0, 2'b00);
    addv(0, 3'b010, 32'h1C,  32'h0,        32'h12340000, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) access(0, vecs[i], i);

    // Reset during the first WAIT cycle drops the pending store.
    v.we = 1; v.f3 = 3'b010; v.a = 32'h20; v.wd = 32'h11111111;
    v.r = 32'h0; v.e = 0; v.c = 2'b00;
    @(negedge clk);
    drive(0, v);
    @(posedge clk);
    #1;
    scramble(0);
    chk("stall_in_wait", 32'(stall[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("wait_reset_stall", 32'(stall[0]), 32'd0);
    chk("wait_reset_done", 32'(done[0]), 32'd0);
    chk("wait_reset_err", 32'(err[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v.we = 0; v.a = 32'h20; v.r = 32'h00000000;
    access(0, v, 100);

    // Reset during RESP clears done at once but keeps the committed store.
    v.we = 1; v.a = 32'h24; v.wd = 32'h22222222; v.r = 32'h0;
    pushExp(0, v, 101);
    @(negedge clk);
    drive(0, v);
    @(posedge clk);
    #1;
    scramble(0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done[0] && cyc < 20);
    chk("resp_reached_before_reset", 32'(cyc), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("resp_reset_done_async", 32'(done[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v.we = 0; v.a = 32'h24; v.r = 32'h22222222;
    access(0, v, 102);

    // Zero-latency instance.
    v.we = 1; v.f3 = 3'b010; v.a = 32'h8; v.wd = 32'hCAFEF00D; v.r = 32'h0; v.e = 0; v.c = 2'b00;
    access(1, v, 200);
    v.we = 0; v.r = 32'hCAFEF00D;
    access(1, v, 201);
    v.f3 = 3'b100; v.a = 32'hB; v.r = 32'h000000CA;
    access(1, v, 202);
    v.f3 = 3'b001; v.a = 32'hA; v.r = 32'hFFFFCAFE;
    access(1, v, 203);
    v.we = 1; v.f3 = 3'b010; v.a = 32'h100; v.wd = 32'h0; v.r = 32'h0; v.e = 1; v.c = 2'b10;
    access(1, v, 204);
    v.we = 0; v.a = 32'h8; v.r = 32'hCAFEF00D; v.e = 0; v.c = 2'b00;
    access(1, v, 205);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty_d0", 32'(q0.size()), 32'd0);
    chk("scoreboard_empty_d1", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Parametrised load/store data memory for the memory stage of the pipelined RV32 core. It is the successor to the fixed single-cycle word-only data memory. It adds:
- byte, halfword and word accesses with sign/zero extension;
- a configurable access latency, with a stall handshake to the hazard unit;
- registered error reporting for misaligned, out-of-range and illegal accesses.

It sits between the M-stage pipeline register and the M/W register and replaces the word-aligned address masking done at the top level.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; must be a power of two, at least 4.
- LATENCY, 2: extra wait cycles per access, legal range 0..7.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  M stage holds a load or store (MemRead | MemWriteM).
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32 width/sign code of the M-stage instruction.
- addr  in  32  byte address (ALUResultM, unmasked).
- wdata  in  32  store data (WriteDataM); low bits used for SB/SH.
- rdata  out  32  extended load data; valid only while done = 1.
- done  out  1  one-cycle pulse marking access completion.
- stall  out  1  to hazard unit; holds F/D/E/M while high.
- err  out  1  completed access was faulted; valid with done.
- err_code  out  2  01 misaligned, 10 out of range, 11 illegal funct3; 00 when err = 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with req_valid = 1:
  - Latch req_we, funct3, addr, wdata.
  - Load the counter with LATENCY.
  - Go to WAIT if LATENCY > 0, otherwise go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
- RESP:
  - Assert done and drive rdata/err/err_code from registers captured on entry.
  - Go to IDLE unconditionally.
  - Inputs are ignored in this cycle.
- stall = (state == IDLE & req_valid) | (state == WAIT). It is 0 in RESP, and the pipeline advances on the edge ending RESP.
- Latched request fields do not change during WAIT, even if the inputs change.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Lane is addr[1:0].
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Error priority: illegal funct3 (11) > misaligned (01) > out of range (10).
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
- A faulted access has identical timing to a good one, but no memory write occurs and rdata = 0.
- Stores use byte enables:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
- The write commits on the edge that enters RESP.
- Loads read the word on the edge entering RESP. The selected lane is sign-extended (LB/LH) or zero-extended (LBU/LHU). For stores, rdata = 0.
- Memory array contents are not affected by reset and are initialised to zero for simulation only.

## Timing
- Reset values: state IDLE, counter 0, rdata 0, done 0, err 0, err_code 00.
- stall is forced to 0 while reset is high.
- A request presented in cycle N:
  - stall is high in cycles N .. N+LATENCY;
  - done is high in cycle N+LATENCY+1.
- Throughput is one access per LATENCY+2 cycles.
- A load issued back-to-back after a store to the same word returns the new data (the write commits before the next read edge).
- Reset asserted in WAIT:
  - FSM returns to IDLE immediately;
  - the pending store is dropped and memory is unchanged;
  - no done pulse is generated.
- Reset asserted in RESP: done deasserts asynchronously. A store completed on the RESP entry edge remains in memory.
- req_valid = 0 in IDLE: no state change, and all outputs hold reset values.

## Test plan
- Store then load, LATENCY = 2: SW 0xDEADBEEF to 0x10, then LW from 0x10.
  - Each access shows stall high for 3 cycles, then done for 1 cycle.
  - Load returns rdata = 0xDEADBEEF with err = 0.
- Byte store and loads: after the above, SB 0x000000A5 to 0x13.
  - LB 0x13 returns 0xFFFFFFA5.
  - LBU 0x13 returns 0x000000A5.
  - LW 0x10 returns 0xA5ADBEEF.
- Halfword accesses: SH 0x00008001 to 0x12, then LH 0x12 returns 0xFFFF8001.
  - LH 0x11 gives err = 1, err_code 01, rdata 0.
  - SW 0x5 gives err_code 01, and word 1 is unchanged.
- Range and illegal: with DEPTH_WORDS = 64, SW 0xFFFFFFFF to 0x100 gives err_code 10, and word 0 is still 0x00000000.
  - LW 0x100 gives rdata 0, err_code 10.
  - funct3 = 011 gives err_code 11.
- Reset mid-operation: SW 0x11111111 to 0x20, then assert reset in the first WAIT cycle.
  - stall, done and err go to 0 at once.
  - After release, LW 0x20 returns the prior value 0x00000000.
- LATENCY = 0 build: SW and LW to 0x8 each show stall for 1 cycle, done in the next cycle, and rdata equal to the stored value.
